// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge
// Single-outstanding APB4 requester. A command accepted on the cmd_* valid/ready
// channel becomes one APB4 SETUP + ACCESS transfer. The result (read data, slave
// error, timeout) is returned on the rsp_* valid/ready channel.
//
// Ports:
//   pclk, preset          clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot   command payload
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err, rsp_timeout                      response payload
//   psel, penable, pwrite, paddr, pwdata, pstrb, pprot   APB4 requester outputs
//   prdata, pready, pslverr                              APB4 completer inputs
//
// DATA_WIDTH must be 8, 16 or 32. TIMEOUT = 0 disables the wait-state timeout.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Abort happens on the edge where the counter would reach TIMEOUT, so at
  // most TIMEOUT ACCESS cycles are spent with pready low.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_WIDTH-1:0]   wait_cnt;
  logic                   cmd_fire;
  logic                   timeout_hit;

  assign cmd_fire    = cmd_valid & cmd_ready;
  assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !pready &&
                       (wait_cnt == CNT_LAST);

  // State register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; RESP always returns to IDLE, never straight to SETUP
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid)              state_next = SETUP;
      SETUP:                               state_next = ACCESS;
      ACCESS:  if (pready || timeout_hit)  state_next = RESP;
      RESP:    if (rsp_ready)              state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // Handshake and APB control outputs are decoded from state alone
  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      SETUP:   psel      = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      RESP:    rsp_valid = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Transfer attributes, wait counter and response capture.
  // APB attributes are only loaded at command accept, so they stay stable
  // through the transfer and keep their last value afterwards.
  always_ff @(posedge pclk) begin
    if (preset) begin
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (cmd_fire) begin
        pwrite   <= cmd_write;
        paddr    <= cmd_addr;
        pwdata   <= cmd_wdata;
        pstrb    <= cmd_write ? cmd_strb : {STRB_WIDTH{1'b0}};
        pprot    <= cmd_prot;
        wait_cnt <= '0;
      end
      if (state == ACCESS) begin
        if (pready) begin
          rsp_rdata   <= pwrite ? {DATA_WIDTH{1'b0}} : prdata;
          rsp_err     <= pslverr;
          rsp_timeout <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge
// Directed bench for apb4_master_bridge (TIMEOUT = 4). The bench plays the APB
// completer by driving pready/prdata/pslverr directly. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_apb4_master_bridge;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int errors = 0;
  int checks = 0;

  apb4_master_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (4)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one clock and land just after the edge
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [2:0] prot);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %0b expected 1", cmd_ready); end
    checks++; if ({psel, penable, rsp_valid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctrl: got psel/penable/rsp_valid=%03b expected 000", {psel, penable, rsp_valid}); end
    checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pprot !== 3'h0 || pwrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_apb: got paddr=%h pwdata=%h pstrb=%h pprot=%h pwrite=%0b expected all 0", paddr, pwdata, pstrb, pprot, pwrite); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp: got rdata=%h err=%0b timeout=%0b expected 0", rsp_rdata, rsp_err, rsp_timeout); end
    preset = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1 || psel !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: got cmd_ready=%0b psel=%0b expected 1/0", cmd_ready, psel); end
  endtask

  task automatic test_zero_wait_write();
    pready  = 1'b1;
    pslverr = 1'b0;
    drive_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
    tick();
    cmd_valid = 1'b0;
    // SETUP
    checks++; if (psel !== 1'b1 || penable !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL zw_setup: got psel=%0b penable=%0b cmd_ready=%0b expected 1/0/0", psel, penable, cmd_ready); end
    checks++; if (paddr !== 32'h10 || pwdata !== 32'hDEADBEEF || pstrb !== 4'hF || pwrite !== 1'b1 || pprot !== 3'b010) begin errors++; $display("[TB] FAIL zw_attr: got paddr=%h pwdata=%h pstrb=%h pwrite=%0b pprot=%0d", paddr, pwdata, pstrb, pwrite, pprot); end
    tick();
    // ACCESS
    checks++; if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL zw_access: got psel=%0b penable=%0b rsp_valid=%0b expected 1/1/0", psel, penable, rsp_valid); end
    tick();
    // RESP
    checks++; if (rsp_valid !== 1'b1 || psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("[TB] FAIL zw_resp: got rsp_valid=%0b psel=%0b penable=%0b expected 1/0/0", rsp_valid, psel, penable); end
    checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL zw_rsp_data: got err=%0b rdata=%h timeout=%0b expected 0/0/0", rsp_err, rsp_rdata, rsp_timeout); end
    tick();
    // Back in IDLE; APB attributes hold
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || paddr !== 32'h10 || pwdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL zw_idle_hold: got rsp_valid=%0b cmd_ready=%0b paddr=%h pwdata=%h", rsp_valid, cmd_ready, paddr, pwdata); end
  endtask

  task automatic test_read_wait2();
    int en_cycles;
    en_cycles = 0;
    pready = 1'b0;
    prdata = 32'h0;
    drive_cmd(1'b0, 32'h24, 32'h55AA55AA, 4'hF, 3'b101);
    tick();
    cmd_valid = 1'b0;
    checks++; if (pstrb !== 4'h0 || pwrite !== 1'b0 || paddr !== 32'h24 || pprot !== 3'b101) begin errors++; $display("[TB] FAIL rd_setup_attr: got pstrb=%h pwrite=%0b paddr=%h pprot=%0d expected 0/0/24/5", pstrb, pwrite, paddr, pprot); end
    tick();
    // Two ACCESS cycles with pready low, third with pready high
    for (int i = 0; i < 3; i++) begin
      if (penable === 1'b1 && psel === 1'b1 && pstrb === 4'h0) en_cycles++;
      if (i == 2) begin
        pready = 1'b1;
        prdata = 32'h12345678;
      end
      tick();
    end
    checks++; if (en_cycles !== 3) begin errors++; $display("[TB] FAIL rd_penable_cycles: got %0d expected 3", en_cycles); end
    checks++; if (rsp_valid !== 1'b1 || penable !== 1'b0 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rd_resp: got rsp_valid=%0b penable=%0b rdata=%h err=%0b expected 1/0/12345678/0", rsp_valid, penable, rsp_rdata, rsp_err); end
    pready = 1'b0;
    prdata = 32'h0;
    tick();
  endtask

  task automatic test_timeout();
    int access_cycles;
    access_cycles = 0;
    pready = 1'b0;
    prdata = 32'hFFFFFFFF;
    drive_cmd(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (psel === 1'b1 && penable === 1'b1 && rsp_valid === 1'b0) access_cycles++;
      tick();
    end
    checks++; if (access_cycles !== 4) begin errors++; $display("[TB] FAIL to_access_cycles: got %0d expected 4", access_cycles); end
    checks++; if (rsp_valid !== 1'b1 || psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("[TB] FAIL to_abort: got rsp_valid=%0b psel=%0b penable=%0b expected 1/0/0", rsp_valid, psel, penable); end
    checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL to_rsp: got err=%0b timeout=%0b rdata=%h expected 1/1/0", rsp_err, rsp_timeout, rsp_rdata); end
    prdata = 32'h0;
    tick();
  endtask

  task automatic test_slave_error();
    // pslverr high only while pready is low must be ignored
    pready  = 1'b0;
    pslverr = 1'b1;
    drive_cmd(1'b1, 32'h30, 32'hA5A50001, 4'h3, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_ignored_wait: got penable=%0b rsp_valid=%0b expected 1/0", penable, rsp_valid); end
    pready  = 1'b1;
    pslverr = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL err_ignored_rsp: got rsp_valid=%0b err=%0b timeout=%0b expected 1/0/0", rsp_valid, rsp_err, rsp_timeout); end
    tick();
    // pslverr high at the pready edge is reported
    pready  = 1'b0;
    pslverr = 1'b0;
    drive_cmd(1'b1, 32'h34, 32'h0BADF00D, 4'hF, 3'b001);
    tick();
    cmd_valid = 1'b0;
    tick();
    pready  = 1'b1;
    pslverr = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL err_sampled: got rsp_valid=%0b err=%0b timeout=%0b rdata=%h expected 1/1/0/0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    pslverr = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int stable_cycles;
    stable_cycles = 0;
    pready    = 1'b1;
    prdata    = 32'hCAFEF00D;
    rsp_ready = 1'b0;
    drive_cmd(1'b0, 32'h50, 32'h0, 4'h0, 3'b000);
    tick();
    // Next command waits on the channel the whole time
    drive_cmd(1'b1, 32'h60, 32'h11223344, 4'hF, 3'b011);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid === 1'b1 && rsp_rdata === 32'hCAFEF00D && rsp_err === 1'b0 &&
          cmd_ready === 1'b0 && psel === 1'b0 && paddr === 32'h50) stable_cycles++;
      tick();
    end
    checks++; if (stable_cycles !== 5) begin errors++; $display("[TB] FAIL bp_stable_cycles: got %0d expected 5", stable_cycles); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_still_valid: got %0b expected 1", rsp_valid); end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got rsp_valid=%0b cmd_ready=%0b psel=%0b expected 0/1/0", rsp_valid, cmd_ready, psel); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h60 || pwrite !== 1'b1 || pwdata !== 32'h11223344 || pprot !== 3'b011) begin errors++; $display("[TB] FAIL bp_next_setup: got psel=%0b penable=%0b paddr=%h pwrite=%0b pwdata=%h pprot=%0d", psel, penable, paddr, pwrite, pwdata, pprot); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL bp_next_resp: got rsp_valid=%0b rdata=%h expected 1/0", rsp_valid, rsp_rdata); end
    prdata = 32'h0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    pready    = 1'b0;
    rsp_ready = 1'b1;
    drive_cmd(1'b0, 32'h70, 32'h0, 4'h0, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++; if (psel !== 1'b1 || penable !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_access: got psel=%0b penable=%0b expected 1/1", psel, penable); end
    preset = 1'b1;
    tick();
    checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || paddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_abort: got psel=%0b penable=%0b rsp_valid=%0b paddr=%h expected 0/0/0/0", psel, penable, rsp_valid, paddr); end
    preset = 1'b0;
    pready = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_after: got cmd_ready=%0b rsp_valid=%0b psel=%0b expected 1/0/0", cmd_ready, rsp_valid, psel); end
    pready = 1'b0;
  endtask

  initial begin
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b1;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    @(negedge pclk);
    test_reset();
    test_zero_wait_write();
    test_read_wait2();
    test_timeout();
    test_slave_error();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
Single-outstanding APB4 requester that converts a valid/ready command channel into APB4 SETUP/ACCESS transfers. It then returns read data and error status on a valid/ready response channel. This is the initiator-side RTL counterpart to the APB4 slave verification environment, and drives that slave in integration benches. It supports wait states through PREADY, PSLVERR, PSTRB and PPROT, and a wait-state timeout.

Parameters:
ADDR_WIDTH, 32, width of paddr and cmd_addr
DATA_WIDTH, 32, width of pwdata/prdata and the command/response data; must be 8, 16 or 32
TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  in  1  clock; all logic on the rising edge
preset  in  1  reset; synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr sampled, or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pprot  out  3  APB protection
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Reset (preset=1 at an edge): state=IDLE, wait counter=0. All outputs are 0 except cmd_ready, which is 1 after reset.
- A reset asserted mid-transfer aborts the transfer without a response. psel/penable are 0 from the edge at which reset is sampled.
- States:
  - IDLE: cmd_ready=1, psel=0, penable=0.
    - On cmd_valid&cmd_ready: register pwrite, paddr, pwdata and pprot from the command. pstrb = cmd_strb for writes, all-zero for reads (APB4 rule). Go to SETUP.
  - SETUP: psel=1, penable=0, cmd_ready=0. Lasts exactly one cycle, then go to ACCESS.
  - ACCESS: psel=1, penable=1.
    - If pready=1 at the edge: capture prdata (reads only, else 0) into rsp_rdata and pslverr into rsp_err; rsp_timeout=0. Go to RESP.
    - If pready=0: the wait counter increments. When TIMEOUT≠0 and the counter equals TIMEOUT at an edge with pready still 0: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - RESP: psel=0, penable=0, rsp_valid=1. rsp_* are held stable until rsp_ready=1. On rsp_valid&rsp_ready: clear rsp_valid, go to IDLE.
- The wait counter clears on entry to SETUP and is wide enough to hold TIMEOUT without wrap.
- pslverr is sampled only when psel&penable&pready. It is ignored otherwise, including on a zero-wait transfer where it is deasserted.
- paddr, pwrite, pwdata, pstrb and pprot are stable from SETUP through the last ACCESS cycle. They hold their last value in RESP and IDLE; they do not return to 0.
- Latency, with command accepted at edge N and pready=1 in the first ACCESS cycle:
  - psel rises after N.
  - penable rises after N+1.
  - rsp_valid rises after N+2.
- Minimum command-to-command spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP); there is no direct RESP→SETUP path.
- cmd_ready is combinational from state only (no dependence on cmd_valid).
- prdata, pready and pslverr are used unregistered only at the ACCESS sampling edge.

Test Plan:
- Zero-wait write: cmd addr=0x10, wdata=0xDEADBEEF, strb=0xF, pready tied 1 → psel high 2 cycles, penable high 1 cycle; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read with 2 wait states: addr=0x24, slave holds pready=0 for 2 ACCESS cycles then returns prdata=0x12345678 → penable high 3 cycles, pstrb=0 throughout, rsp_rdata=0x12345678.
- Slave error: write with pslverr=1 at the pready edge → rsp_err=1, rsp_timeout=0. Also drive pslverr=1 while pready=0 → it is ignored.
- Timeout: TIMEOUT=4, pready stuck 0 → exactly 4 wait cycles counted, then abort; rsp_err=1, rsp_timeout=1, psel=0 the next cycle, rsp_rdata=0.
- Response backpressure: rsp_ready=0 for 5 cycles with cmd_valid held high → rsp_* stable, cmd_ready=0, no new psel. After rsp_ready=1, the next command is accepted one cycle later.
- Reset mid-ACCESS: preset=1 during a waited read → psel/penable 0 next cycle, no rsp_valid, cmd_ready=1 after reset deasserts.
